// File: rtl/trap_bank_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trap_bank_unit_pkg
// Brief    : Shared types and constants for the trap/bank unit.
// Revision : 1.0
// ============================================================================
package trap_bank_unit_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        LOW_READ = 2'd2
    } state_t;

    localparam int c_bank_idx_w        = 3;
    localparam int c_num_banks         = 1 << c_bank_idx_w;
    localparam int c_default_page_bits = 8;

    // Pin-side sample carried through the delay line alongside the strobes.
    typedef struct packed {
        logic        trans_direction;
        logic [1:0]  lo_addr;
        logic [7:0]  data_in;
        logic [15:0] addr;
    } sample_t;

endpackage
`default_nettype wire

// File: rtl/trap_bank_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : trap_bank_unit_if
// Brief    : Z80-side bus bundle between the mapper glue and the trap/bank unit.
// Revision : 1.0
// ============================================================================
interface trap_bank_unit_if
    import trap_bank_unit_pkg::*;
#(
    parameter int PAGE_BITS = c_default_page_bits
);
    logic [15:0]          addr;
    logic [7:0]           data_in;
    logic [1:0]           lo_addr;
    logic                 trap_addr_wr_n;
    logic                 trap_addr_rd_n;
    logic                 bank_wr_n;
    logic                 trans_addr;
    logic                 trans_direction;
    logic [7:0]           data_out;
    logic                 data_oe;
    logic [PAGE_BITS-1:0] phys_page;
    logic                 trap_pending;
    logic                 trap_overflow;

    modport master (
        output addr, data_in, lo_addr, trap_addr_wr_n, trap_addr_rd_n,
               bank_wr_n, trans_addr, trans_direction,
        input  data_out, data_oe, phys_page, trap_pending, trap_overflow
    );

    modport slave (
        input  addr, data_in, lo_addr, trap_addr_wr_n, trap_addr_rd_n,
               bank_wr_n, trans_addr, trans_direction,
        output data_out, data_oe, phys_page, trap_pending, trap_overflow
    );
endinterface
`default_nettype wire

// File: rtl/trap_bank_unit_strobe_sync.sv
`default_nettype none
// ============================================================================
// Module   : trap_bank_unit_strobe_sync
// Brief    : Active-low strobe synchroniser with falling-edge pulse.
// Revision : 1.0
// ============================================================================
module trap_bank_unit_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic strobe_n,
    output logic      level_n,
    output logic      fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Reset to the asserted level so a strobe held low across release is not seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], strobe_n};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level_n = r_sync[SYNC_STAGES-1];
    assign fall    = r_prev & ~r_sync[SYNC_STAGES-1];
endmodule
`default_nettype wire

// File: rtl/trap_bank_unit.sv
`default_nettype none
// ============================================================================
// Module   : trap_bank_unit
// Brief    : Trap-address capture, read-back and bank translation registers.
// Revision : 1.0
// ============================================================================
module trap_bank_unit
    import trap_bank_unit_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PAGE_BITS   = c_default_page_bits
) (
    input  wire logic       clk,
    input  wire logic       reset,
    trap_bank_unit_if.slave bus
);
    localparam int c_str_cap  = 0;
    localparam int c_str_rd   = 1;
    localparam int c_str_bank = 2;

    logic [2:0] w_strobe_n;
    logic [2:0] w_level_n;
    logic [2:0] w_fall;

    assign w_strobe_n = {bus.bank_wr_n, bus.trap_addr_rd_n, bus.trap_addr_wr_n};

    for (genvar g = 0; g < 3; g++) begin : g_sync
        trap_bank_unit_strobe_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk      (clk),
            .reset    (reset),
            .strobe_n (w_strobe_n[g]),
            .level_n  (w_level_n[g]),
            .fall     (w_fall[g])
        );
    end

    // Data path delayed by the synchroniser depth so it lines up with the edge pulses.
    sample_t r_dly [SYNC_STAGES];
    sample_t w_smp;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_dly[0] <= '{trans_direction: bus.trans_direction, lo_addr: bus.lo_addr,
                          data_in: bus.data_in, addr: bus.addr};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign w_smp = r_dly[SYNC_STAGES-1];

    logic [PAGE_BITS-1:0] r_bank [c_num_banks];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_num_banks; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_fall[c_str_bank]) begin
            r_bank[{w_smp.trans_direction, w_smp.lo_addr}] <= PAGE_BITS'(w_smp.data_in);
        end
    end

    logic [c_bank_idx_w-1:0] w_phys_idx;

    assign w_phys_idx    = {bus.trans_direction, bus.addr[15:14]};
    assign bus.phys_page = bus.trans_addr ? r_bank[w_phys_idx] : PAGE_BITS'(bus.addr[15:14]);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_trap, w_trap_nxt;
    logic        r_ovf, w_ovf_nxt;
    logic [7:0]  r_dout, w_dout_nxt;
    logic        r_oe;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_trap  <= '0;
            r_ovf   <= 1'b0;
            r_dout  <= '0;
            r_oe    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_trap  <= w_trap_nxt;
            r_ovf   <= w_ovf_nxt;
            r_dout  <= w_dout_nxt;
            r_oe    <= ~w_level_n[c_str_rd];
        end
    end

    // A coincident read is resolved against the old state before the capture lands.
    always_comb begin
        w_state_nxt = r_state;
        w_trap_nxt  = r_trap;
        w_ovf_nxt   = r_ovf;
        w_dout_nxt  = r_dout;

        if (w_fall[c_str_rd]) begin
            if (!w_smp.lo_addr[0]) begin
                w_dout_nxt = r_trap[7:0];
                if (r_state == PENDING) begin
                    w_state_nxt = LOW_READ;
                end
            end else begin
                w_dout_nxt  = r_trap[15:8];
                w_state_nxt = IDLE;
                w_ovf_nxt   = 1'b0;
            end
        end

        if (w_fall[c_str_cap]) begin
            if (w_state_nxt == IDLE) begin
                w_trap_nxt  = w_smp.addr;
                w_state_nxt = PENDING;
            end else begin
                w_ovf_nxt = 1'b1;
            end
        end
    end

    assign bus.data_out      = r_dout;
    assign bus.data_oe       = r_oe;
    assign bus.trap_pending  = (r_state != IDLE);
    assign bus.trap_overflow = r_ovf;
endmodule
`default_nettype wire

// File: doc/trap_bank_unit.md
Name: trap_bank_unit

Overview:
- Clocked companion to the mapper glue logic; consumes its trap and bank strobes (trap_addr_wr_n, trap_addr_rd_n, bank_wr_n, trans_addr, trans_direction).
- Synchronises the asynchronous Z80 strobes into the clock domain and captures the 16-bit address of an I/O violation.
- Returns the captured address as two readable bytes and holds the bank translation registers.
- Produces the translated physical page for the external memory.

Parameters:
- SYNC_STAGES, 2, flops per strobe synchroniser (min 2).
- PAGE_BITS, 8, width of one physical page number (16 KiB pages).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- addr  in  16  Z80 address bus.
- data_in  in  8  Z80 data bus, write direction.
- lo_addr  in  2  mapper port select (A1..A0).
- trap_addr_wr_n  in  1  async active-low trap-capture strobe.
- trap_addr_rd_n  in  1  async active-low trap-address read strobe.
- bank_wr_n  in  1  async active-low bank-register write strobe.
- trans_addr  in  1  translation enable.
- trans_direction  in  1  table select (0 = in/read, 1 = out/write).
- data_out  out  8  read-back byte.
- data_oe  out  1  data_out drive enable.
- phys_page  out  PAGE_BITS  translated page for addr[15:14].
- trap_pending  out  1  unread capture present.
- trap_overflow  out  1  capture lost while pending.

Behaviour:
- Input pipeline:
  - Each strobe passes through SYNC_STAGES flops, plus one edge-detect flop.
  - addr, data_in and lo_addr are delayed by the same depth, so sampled values align with the detected edge.
  - An action fires on the falling edge (assertion) only, SYNC_STAGES+1 clocks after the pin falls.
- Reset:
  - Synchroniser and edge flops load 0 (asserted), so a strobe held low across reset release does not fire.
  - All other registers clear: banks = 0, trap address = 0, data_out = 0, data_oe = 0, trap_pending = 0, trap_overflow = 0, FSM = IDLE.
  - Reset mid-capture or mid-read discards the operation silently.
- Bank registers: 8 entries of PAGE_BITS, indexed {trans_direction, lo_addr[1:0]}, all sampled at the edge.
  - On a bank_wr_n edge, the entry at that index is loaded with data_in, zero-extended if PAGE_BITS > 8.
- phys_page (combinational from registered state):
  - trans_addr = 1: bank[{trans_direction, addr[15:14]}].
  - trans_addr = 0: {zeros, addr[15:14]}.
- Capture FSM states: IDLE, PENDING, LOW_READ.
  - Capture edge in IDLE: latch addr, go to PENDING, set trap_pending.
  - Capture edge in PENDING or LOW_READ: keep the first address, set trap_overflow (sticky).
  - Read edge, lo_addr[0] = 0: data_out = trap[7:0]; PENDING goes to LOW_READ, other states unchanged.
  - Read edge, lo_addr[0] = 1: data_out = trap[15:8]; any state goes to IDLE; clears trap_pending and trap_overflow.
  - Read in IDLE returns the last captured bytes; there is no state change other than high-read clearing.
- data_oe: high while the synchronised trap_addr_rd_n is low; data_out holds its value between reads.
- Simultaneous events:
  - Read edge plus capture edge in the same cycle: the read is processed first using the old state, then the capture applies to the resulting state. High-read plus capture therefore yields PENDING with the new address and no overflow.
  - Bank write plus capture in the same cycle: both are performed.
- Glitch tolerance: a strobe pulse shorter than one clock may be missed; no partial action is allowed.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE = 2'd0, PENDING = 2'd1, LOW_READ = 2'd2).
  - Bank index width constant (3).
  - Default PAGE_BITS.
- One sub-module, strobe_sync: a SYNC_STAGES synchroniser with reset-to-asserted and a falling-edge pulse output. It is instantiated three times.
- The aligned data/address delay line stays in the top level.

Test Plan:
- Reset, then hold bank_wr_n low through release -> no bank write, all banks 0, phys_page = 0 with trans_addr = 1.
- Bank write: trans_direction = 1, lo_addr = 2, data_in = 0x5A, then addr = 0x8000, trans_addr = 1, direction 1 -> phys_page = 0x5A; direction 0 -> 0x00; trans_addr = 0 -> 0x02.
- Capture at addr = 0x1234 -> trap_pending = 1 after SYNC_STAGES+1 clocks. Read lo_addr[0] = 0 -> data_out = 0x34, FSM LOW_READ. Read lo_addr[0] = 1 -> 0x12, trap_pending = 0.
- Captures at 0xBEEF then 0xCAFE with no read -> trap_overflow = 1. High read returns 0xBE and clears both flags.
- High-read edge coincident with capture of 0x4321 -> data_out = old high byte, FSM PENDING, trap_overflow = 0. Next low read returns 0x21.
- Reset asserted in LOW_READ -> FSM IDLE, trap_pending = 0, data_out = 0, banks cleared.
